// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage
//   One handshaked pipeline stage between Decode and Execute with a 2-entry
//   skid buffer. Back-pressure replaces the old global stall enable. Flush
//   turns the stage into a bubble, which presents an all-zero payload.
//   Saturating counters track bubble and stall cycles.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake
//   in_data   [DATA_W]     upstream payload (opaque)
//   out_valid/out_ready    downstream handshake
//   out_data  [DATA_W]     payload to Execute, zero whenever out_valid=0
//   flush                  synchronous kill of held and incoming payloads
//   cnt_clr                synchronous clear of both counters
//   bubble_cnt [CNT_W]     cycles with out_valid=0 (saturating)
//   stall_cnt  [CNT_W]     cycles with out_valid=1 and out_ready=0 (saturating)
module id_ex_skid_stage #(
  parameter int DATA_W = 122,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State and payload registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

  // Next state. Every path into EMPTY also zeroes main, so main is zero
  // whenever the stage is empty; skid is zero whenever it is unused.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_nxt  = in_data;
            state_nxt = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            skid_nxt  = in_data;
            state_nxt = FULL;
          end else if (out_fire) begin
            main_nxt  = '0;
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain case exists.
          if (out_fire) begin
            main_nxt  = skid_q;
            skid_nxt  = '0;
            state_nxt = ONE;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = '0;
          skid_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only: no out_ready -> in_ready path.
  always_comb begin
    in_ready  = (state != FULL);
    out_valid = (state != EMPTY);
    out_data  = out_valid ? main_q : '0;
  end

  // Performance counters, one cycle behind the conditions they count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (!out_valid && bubble_cnt != CNT_MAX)
        bubble_cnt <= bubble_cnt + CNT_ONE;
      if (out_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/id_ex_skid_stage.md
# id_ex_skid_stage

Parametrised, handshaked successor to the fixed-field ID/EX pipeline register: a single pipeline stage carrying a `DATA_W`-bit packed payload with valid/ready flow control and a 2-entry skid buffer. It sits between Decode and Execute (or any other stage boundary). Stalls propagate as back-pressure rather than as a global enable. It keeps the existing flush-to-bubble semantics: a flushed stage presents an all-zero payload. It also counts bubble and stall cycles for performance analysis.

## Interface
Parameters:
- `DATA_W`, 122, payload width; default equals the packed EX/MEM/WB control, Rs/Rt/Rd, RD1/RD2 and SignImm bundle.
- `CNT_W`, 16, width of the saturating performance counters.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream (Decode) payload valid.
- `in_ready`  out  1  stage can accept a payload this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  payload presented to Execute is valid.
- `out_ready`  in  1  Execute accepts the payload this cycle.
- `out_data`  out  DATA_W  payload to Execute; all-zero when `out_valid`=0.
- `flush`  in  1  synchronous kill of all held and incoming payloads (FlushE equivalent).
- `cnt_clr`  in  1  synchronous clear of both counters.
- `bubble_cnt`  out  CNT_W  cycles with `out_valid`=0, saturating.
- `stall_cnt`  out  CNT_W  cycles with `out_valid`=1 and `out_ready`=0, saturating.

## Operation
- Storage: main register (drives `out_data`) and skid register.
- Occupancy state: EMPTY (0 entries), ONE (main only), FULL (main + skid).
- Handshake events: `in_fire` = `in_valid` & `in_ready`; `out_fire` = `out_valid` & `out_ready`.
- `in_ready` = state != FULL. `out_valid` = state != EMPTY. Both are decoded from registered state only; there is no combinational path from `out_ready` to `in_ready`.
- State transitions (no flush):
  - EMPTY: on `in_fire`, main <= `in_data`, go to ONE.
  - ONE, `in_fire` & `out_fire`: main <= `in_data`, stay in ONE.
  - ONE, `in_fire` only: skid <= `in_data`, go to FULL.
  - ONE, `out_fire` only: main <= 0, go to EMPTY.
  - FULL, `out_fire`: main <= skid, skid <= 0, go to ONE.
  - Any other combination: hold state and data.
- `flush`=1 has priority over every other event. Next state is EMPTY, main and skid <= 0.
  - A payload accepted (`in_fire`) in the flush cycle is discarded.
  - A payload consumed (`out_fire`) in the flush cycle counts as delivered.
- Payload is opaque; no field is interpreted. Ordering is strictly FIFO; payloads are never duplicated or dropped except by flush.
- Counters update every cycle. `cnt_clr` has priority over increment. Each counter holds at 2^CNT_W−1 once reached. `flush` does not affect the counters.

## Timing
- Reset (`rst_n`=0, asynchronous): state EMPTY, main = skid = 0, `out_valid`=0, `out_data`=0, `in_ready`=1, `bubble_cnt`=`stall_cnt`=0.
- Reset release: the first rising edge with `rst_n`=1 is a normal cycle.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Latency: a payload accepted at edge N into an EMPTY stage appears on `out_data` with `out_valid`=1 immediately after edge N (1 cycle).
- Throughput: 1 payload per cycle while `out_ready`=1.
- Back-pressure: after `out_ready` drops, the stage absorbs at most one more payload, then `in_ready`=0 from the following cycle.
- Flush at edge N: `out_valid`=0 and `out_data`=0 after edge N; `in_ready`=1 after edge N.
- Counters reflect the previous cycle's conditions (registered).

## Test plan
- Reset, then DATA_W=122 stream of values 1..8 with `out_ready`=1 -> outputs 1..8 on consecutive cycles, one cycle behind input; `bubble_cnt` counts only idle cycles, `stall_cnt`=0.
- Stream 1..4, `out_ready`=0 for 3 cycles starting when 1 is output -> 2 captured in skid, `in_ready`=0 next cycle, `stall_cnt`=3; on release, outputs 1,2,3,4 with none lost or duplicated.
- FULL with values 5 (main) and 6 (skid), `flush`=1 with `in_valid`=1 carrying 7 -> next cycle `out_valid`=0, `out_data`=0, `in_ready`=1; 5, 6 and 7 never appear.
- ONE with `in_fire` and `out_fire` simultaneous -> state stays ONE, `out_data` = new payload, `in_ready` remains 1.
- CNT_W=4, idle for 20 cycles -> `bubble_cnt` saturates at 15; `cnt_clr`=1 together with an idle cycle -> `bubble_cnt`=0 next cycle.
- Assert `rst_n`=0 between edges while FULL -> all outputs zero and `in_ready`=1 before the next edge.
